// File: rtl/sqrt_stream_ctrl_if.sv
// Bundle of the operand stream, result stream and square-root core port used by sqrt_stream_ctrl.
// Streams transfer a word on any posedge where valid && ready; valid never waits on ready, and data is stable while valid is high.
interface sqrt_stream_ctrl_if #(
  parameter int W = 20
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  logic [W-1:0] out_data;
  logic         out_err;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  logic         sq_reset;
  logic [W-1:0] sq_in;
  logic         sq_input_ready;
  logic         sq_output_taken;
  logic [W-1:0] sq_out;
  logic [1:0]   sq_state;

  // Controller FSM state, exported for observation only
  logic [2:0]   dbg_state;

  modport master (
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_err, out_last, out_valid,
    input  out_ready,
    output sq_reset, sq_in, sq_input_ready, sq_output_taken,
    input  sq_out, sq_state,
    output dbg_state
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_err, out_last, out_valid,
    output out_ready,
    input  sq_reset, sq_in, sq_input_ready, sq_output_taken,
    output sq_out, sq_state,
    input  dbg_state
  );
endinterface

// File: rtl/sqrt_stream_ctrl.sv
// Streams signed Q(IL).(FL) operands through a small FIFO into the iterative sqrt core and
// returns Q(IL).(FL) roots with an error flag for negative inputs and a per-vector last marker.
module sqrt_stream_ctrl #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int DEPTH = 4,
  parameter int N     = 8
) (
  input  logic               clk,
  input  logic               reset,
  sqrt_stream_ctrl_if.master bus
);
  localparam int W  = IL + FL;
  localparam int HW = W / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_TAKE  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [1:0] CORE_IDLE = 2'b00;
  localparam logic [1:0] CORE_HELD = 2'b10;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [W-1:0]  head;
  logic          head_neg;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] elem_cnt;
  logic [W-1:0]  out_data_q;
  logic          out_err_q;
  logic [W-1:0]  sq_in_q;
  logic [W-1:0]  root_scaled;
  logic          unused_sq_out_hi;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_neg = head[W-1];

  assign bus.in_ready = reset && !full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = ((state == S_IDLE) && !empty && head_neg) || (state == S_ISSUE);

  // The root of a W-bit word has W/2 bits; shifting by FL/2 restores the fraction scale
  assign root_scaled      = {{(W - HW){1'b0}}, bus.sq_out[HW-1:0]} << (FL / 2);
  assign unused_sq_out_hi = ^bus.sq_out[W-1:HW];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head_neg)                       state_nxt = S_HOLD;
          else if (bus.sq_state == CORE_IDLE) state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.sq_state == CORE_HELD) state_nxt = S_TAKE;
      S_TAKE:  state_nxt = S_HOLD;
      S_HOLD:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      elem_cnt   <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      sq_in_q    <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Operand is registered one cycle early so it is already stable during the issue pulse
      if ((state == S_IDLE) && (state_nxt == S_ISSUE)) sq_in_q <= head;
      if ((state == S_IDLE) && (state_nxt == S_HOLD)) begin
        out_data_q <= '0;
        out_err_q  <= 1'b1;
      end
      if (state == S_TAKE) begin
        out_data_q <= root_scaled;
        out_err_q  <= 1'b0;
      end
      if ((state == S_HOLD) && bus.out_ready)
        elem_cnt <= (elem_cnt == LAST_IDX) ? '0 : elem_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  assign bus.out_data        = out_data_q;
  assign bus.out_err         = out_err_q;
  assign bus.out_valid       = (state == S_HOLD);
  assign bus.out_last        = (state == S_HOLD) && (elem_cnt == LAST_IDX);
  assign bus.sq_reset        = ~reset;
  assign bus.sq_in           = sq_in_q;
  assign bus.sq_input_ready  = (state == S_ISSUE);
  assign bus.sq_output_taken = (state == S_TAKE);
  assign bus.dbg_state       = state;
endmodule

// File: tb/tb_sqrt_stream_ctrl.sv
// Directed bench for sqrt_stream_ctrl with a behavioural sqrt core of random latency.
module tb_sqrt_stream_ctrl;
  localparam int IL = 4, FL = 16, DEPTH = 4, N = 8, W = IL + FL;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sqrt_stream_ctrl_if #(.W(W)) bus ();

  sqrt_stream_ctrl #(.IL(IL), .FL(FL), .DEPTH(DEPTH), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural core: 00 idle, 01 busy for a random number of cycles, 10 result held until taken
  logic [1:0]   core_state = 2'b00;
  logic [W-1:0] core_raw = '0;
  logic [W-1:0] core_res = '0;
  int           core_lat = 0;
  assign bus.sq_state = core_state;
  assign bus.sq_out   = core_res;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    int unsigned r, t;
    r = 0;
    for (int b = W / 2 - 1; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= 32'(x)) r = t;
    end
    return W'(r);
  endfunction

  always @(posedge clk) begin
    if (bus.sq_reset) begin
      core_state <= 2'b00;
      core_lat   <= 0;
      core_res   <= '0;
    end else begin
      case (core_state)
        2'b00: if (bus.sq_input_ready) begin
          core_raw   <= bus.sq_in;
          core_lat   <= $urandom_range(2, 12);
          core_state <= 2'b01;
        end
        2'b01: if (core_lat <= 1) begin
          core_res   <= isqrt(core_raw);
          core_state <= 2'b10;
        end else core_lat <= core_lat - 1;
        2'b10: if (bus.sq_output_taken) core_state <= 2'b00;
        default: core_state <= 2'b00;
      endcase
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entries are {last, err, data}
  logic [W+1:0] exp_q[$];
  int elem_idx = 0;
  int issue_cnt = 0, take_cnt = 0, n_results = 0, last_seen = 0;

  task automatic expect_result(input logic err, input logic [W-1:0] data);
    logic last;
    last = (elem_idx == N - 1);
    exp_q.push_back({last, err, data});
    elem_idx = (elem_idx == N - 1) ? 0 : elem_idx + 1;
  endtask

  initial begin
    logic prev_ir, prev_ot;
    logic [W+1:0] e;
    prev_ir = 1'b0;
    prev_ot = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.sq_input_ready) begin
          check("issue_core_idle", 32'(bus.sq_state), 32'd0);
          check("issue_one_cycle", 32'(prev_ir), 32'd0);
          issue_cnt++;
        end
        if (bus.sq_output_taken) begin
          check("take_core_held", 32'(bus.sq_state), 32'd2);
          check("take_one_cycle", 32'(prev_ot), 32'd0);
          check("sq_in_held", 32'(bus.sq_in), 32'(core_raw));
          take_cnt++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 32'(bus.out_data), 32'hDEAD);
          else begin
            e = exp_q.pop_front();
            check("out_data", 32'(bus.out_data), 32'(e[W-1:0]));
            check("out_err", 32'(bus.out_err), 32'(e[W]));
            check("out_last", 32'(bus.out_last), 32'(e[W+1]));
            n_results++;
            if (bus.out_last) last_seen++;
          end
        end
      end
      prev_ir = bus.sq_input_ready && reset;
      prev_ot = bus.sq_output_taken && reset;
    end
  end

  task automatic push(input logic [W-1:0] d);
    int guard;
    guard = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) check("push_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    reset = 1'b1;
    elem_idx = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] ops [6];
    logic [W-1:0] res [6];
    int i0, t0, r0, l0, acc, cycles, k;
    logic took;

    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_sq_reset", 32'(bus.sq_reset), 32'd1);
    check("rst_sq_in", 32'(bus.sq_in), 32'd0);
    check("rst_sq_input_ready", 32'(bus.sq_input_ready), 32'd0);
    check("rst_sq_output_taken", 32'(bus.sq_output_taken), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("run_in_ready", 32'(bus.in_ready), 32'd1);
    check("run_sq_reset", 32'(bus.sq_reset), 32'd0);
    bus.out_ready = 1'b1;

    // 4.0 -> 2.0, one issue and one take
    i0 = issue_cnt; t0 = take_cnt;
    expect_result(1'b0, 20'h20000);
    push(20'h40000);
    wait_drain("t1_drain");
    check("t1_issues", 32'(issue_cnt - i0), 32'd1);
    check("t1_takes", 32'(take_cnt - t0), 32'd1);

    // 2.25, 0, max positive
    expect_result(1'b0, 20'h18000);
    expect_result(1'b0, 20'h00000);
    expect_result(1'b0, 20'h2D400);
    push(20'h24000);
    push(20'h00000);
    push(20'h7FFFF);
    wait_drain("t2_drain");

    // Negative operand bypasses the core
    i0 = issue_cnt;
    bus.out_ready = 1'b0;
    expect_result(1'b1, 20'h00000);
    push(20'hFFFFF);
    cycles = 0;
    while (!bus.out_valid && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("neg_valid", 32'(bus.out_valid), 32'd1);
    check("neg_latency_le2", 32'(cycles <= 2), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("neg_no_issue", 32'(issue_cnt - i0), 32'd0);
    expect_result(1'b0, 20'h10000);
    push(20'h10000);
    wait_drain("t3_drain");
    check("neg_then_pos_issue", 32'(issue_cnt - i0), 32'd1);

    // Back-pressure: one in flight plus DEPTH buffered
    ops = '{20'h01000, 20'h09000, 20'h19000, 20'h31000, 20'h51000, 20'h79000};
    res = '{20'h04000, 20'h0C000, 20'h14000, 20'h1C000, 20'h24000, 20'h2C000};
    for (int j = 0; j < 6; j++) expect_result(1'b0, res[j]);
    r0 = n_results;
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (acc < 6) begin
        bus.in_data = ops[acc];
        bus.in_valid = 1'b1;
        took = bus.in_ready;
        @(posedge clk); #1;
        if (took) acc++;
      end
    end
    check("fifo_accept_count", 32'(acc), 32'd5);
    check("fifo_in_ready_full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = acc; j < 6; j++) push(ops[j]);
    wait_drain("t4_drain");
    check("fifo_result_count", 32'(n_results - r0), 32'd6);

    // Vector framing after a clean reset: last on the 8th and 16th
    pulse_reset(2);
    l0 = last_seen;
    for (int j = 0; j < 16; j++) begin
      k = 40 * j + 3;
      expect_result(1'b0, W'(k << 8));
      push(W'(k * k));
    end
    wait_drain("t5_drain");
    check("t5_last_count", 32'(last_seen - l0), 32'd2);
    check("issue_take_balance", 32'(issue_cnt), 32'(take_cnt));

    // Reset while the core is busy, with the element counter part-way through a vector
    for (int j = 0; j < 3; j++) begin
      expect_result(1'b0, 20'h10000);
      push(20'h10000);
    end
    wait_drain("t6_pre_drain");
    push(20'h40000);
    cycles = 0;
    while (core_state != 2'b01 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("t6_reached_wait", 32'(core_state), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_sq_reset", 32'(bus.sq_reset), 32'd1);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    elem_idx = 0;
    r0 = n_results;
    repeat (20) begin @(posedge clk); #1; end
    check("t6_no_aborted_out", 32'(n_results - r0), 32'd0);
    l0 = last_seen;
    expect_result(1'b0, 20'h10000);
    push(20'h10000);
    for (int j = 0; j < 7; j++) begin
      expect_result(1'b0, 20'h20000);
      push(20'h40000);
    end
    wait_drain("t6_drain");
    check("t6_last_count", 32'(last_seen - l0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
